// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, CRC helpers and FSM state type for the MAC frame builder
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam int          MIN_PAYLOAD   = 46;
  // preamble(7) + SFD(1) + dest(6) + src(6) + type(2)
  localparam int          HDR_BYTES     = 22;
  localparam int          FCS_BYTES     = 4;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  // The wire sends bytes LSB first, so the CRC runs in the reflected domain.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      r[b] = v[31-b];
    end
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/crc32_64.sv
// rtl/crc32_64.sv - combinational CRC-32 update over up to eight byte lanes per cycle
module crc32_64
  import mac_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_lane_en,
  output logic [31:0] o_crc
);

  logic [31:0] crc_w;

  // Fold enabled lanes in wire order (lane 0 first), one reflected byte step each
  always_comb begin
    crc_w = i_crc;
    for (int l = 0; l < 8; l++) begin
      if (i_lane_en[l]) begin
        crc_w = crc_w ^ {24'd0, i_data[8*l +: 8]};
        for (int b = 0; b < 8; b++) begin
          crc_w = crc_w[0] ? ((crc_w >> 1) ^ CRC_POLY_REFL) : (crc_w >> 1);
        end
      end
    end
    o_crc = crc_w;
  end

endmodule

// File: rtl/mac_frame_gen.sv
// rtl/mac_frame_gen.sv - Ethernet MAC TX frame builder emitting 64-bit words
module mac_frame_gen
  import mac_pkg::*;
#(
  parameter int         PAYLOAD_MAX_SIZE     = 64,
  parameter logic [7:0] PAYLOAD_CHAR_PATTERN = 8'h00,
  parameter int         PAYLOAD_LENGTH       = 46
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [47:0] i_dest_address,
  input  logic [47:0] i_src_address,
  input  logic [15:0] i_eth_type,
  input  logic [15:0] i_payload_length,
  input  logic [7:0]  i_payload [PAYLOAD_MAX_SIZE],
  output logic        o_valid,
  output logic [63:0] o_frame_out,
  output logic        o_done
);

  localparam int PIDX_W = (PAYLOAD_MAX_SIZE > 1) ? $clog2(PAYLOAD_MAX_SIZE) : 1;

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [47:0] dest_q, dest_d, src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [15:0] len_q, len_d;
  logic [15:0] total_q, total_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  payload_q [PAYLOAD_MAX_SIZE];
  logic [7:0]  payload_d [PAYLOAD_MAX_SIZE];
  logic [31:0] crc_q, crc_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [63:0] frame_q, frame_d;

  logic        start_edge;
  int          l_eff, p_eff, data_end;
  logic [63:0] data_word, fcs_word, word;
  logic [7:0]  lane_en;
  logic [31:0] crc_next, fcs;

  assign start_d    = i_start;
  assign start_edge = i_start & ~start_q;
  // First FCS byte position; everything from dest up to here feeds the CRC
  assign data_end   = int'(total_q) - FCS_BYTES;

  // Byte at wire position p (p >= 8) taken from the latched fields
  function automatic logic [7:0] data_byte(input int p);
    logic [47:0] t48;
    logic [15:0] t16;
    logic [7:0]  b;
    b   = 8'h00;
    t48 = '0;
    t16 = '0;
    if (p < 14) begin
      t48 = dest_q >> (8 * (13 - p));
      b   = t48[7:0];
    end else if (p < 20) begin
      t48 = src_q >> (8 * (19 - p));
      b   = t48[7:0];
    end else if (p < HDR_BYTES) begin
      t16 = type_q >> (8 * (21 - p));
      b   = t16[7:0];
    end else if (p < HDR_BYTES + int'(len_q)) begin
      b = payload_q[PIDX_W'(p - HDR_BYTES)];
    end else if (p < data_end) begin
      b = PAYLOAD_CHAR_PATTERN;
    end
    return b;
  endfunction

  function automatic logic [7:0] fcs_byte(input int k);
    logic [31:0] t32;
    t32 = fcs >> (8 * k);
    return t32[7:0];
  endfunction

  // Effective payload length: default for zero, clamp to array depth, pad to minimum
  always_comb begin
    l_eff = (i_payload_length == 16'd0) ? PAYLOAD_LENGTH : int'(i_payload_length);
    if (l_eff > PAYLOAD_MAX_SIZE) begin
      l_eff = PAYLOAD_MAX_SIZE;
    end
    p_eff = (l_eff < MIN_PAYLOAD) ? MIN_PAYLOAD : l_eff;
  end

  // Data lanes of the current word and the matching CRC lane enables
  always_comb begin
    data_word = '0;
    lane_en   = '0;
    for (int l = 0; l < 8; l++) begin
      if ((int'(idx_q) + l >= 8) && (int'(idx_q) + l < data_end)) begin
        data_word[8*l +: 8] = data_byte(int'(idx_q) + l);
        lane_en[l]          = 1'b1;
      end
    end
  end

  crc32_64 u_crc (
    .i_crc     (crc_q),
    .i_data    (data_word),
    .i_lane_en (lane_en),
    .o_crc     (crc_next)
  );

  // FCS includes this word's data lanes, so it is valid even when data and FCS share a word
  assign fcs = ~crc_next;

  // Place FCS bytes (LSB first) into whichever lanes they fall in this word
  always_comb begin
    fcs_word = '0;
    for (int l = 0; l < 8; l++) begin
      if ((int'(idx_q) + l >= data_end) && (int'(idx_q) + l < data_end + FCS_BYTES)) begin
        fcs_word[8*l +: 8] = fcs_byte(int'(idx_q) + l - data_end);
      end
    end
  end

  assign word = data_word | fcs_word;

  // Next-state logic: latch on start edge, stream words, then flag completion
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    src_d     = src_q;
    type_d    = type_q;
    len_d     = len_q;
    total_d   = total_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    crc_d     = crc_q;
    valid_d   = 1'b0;
    frame_d   = '0;
    done_d    = done_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          dest_d    = i_dest_address;
          src_d     = i_src_address;
          type_d    = i_eth_type;
          payload_d = i_payload;
          len_d     = 16'(l_eff);
          total_d   = 16'(HDR_BYTES + p_eff + FCS_BYTES);
          crc_d     = CRC_INIT;
          idx_d     = 16'd8;
          done_d    = 1'b0;
          valid_d   = 1'b1;
          frame_d   = {SFD, {7{PREAMBLE_BYTE}}};
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        valid_d = 1'b1;
        frame_d = word;
        crc_d   = crc_next;
        idx_d   = idx_q + 16'd8;
        if ((idx_q + 16'd8) >= total_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      dest_q  <= '0;
      src_q   <= '0;
      type_q  <= '0;
      len_q   <= '0;
      total_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < PAYLOAD_MAX_SIZE; i++) begin
        payload_q[i] <= '0;
      end
      crc_q   <= CRC_INIT;
      valid_q <= 1'b0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      type_q    <= type_d;
      len_q     <= len_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      crc_q     <= crc_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_frame_out = frame_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_mac_frame_gen.sv
// tb/tb_mac_frame_gen.sv - randomized self-checking bench for mac_frame_gen
module tb_mac_frame_gen;

  localparam int MAXP = 64;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [47:0] i_dest_address;
  logic [47:0] i_src_address;
  logic [15:0] i_eth_type;
  logic [15:0] i_payload_length;
  logic [7:0]  i_payload [MAXP];
  logic        o_valid;
  logic [63:0] o_frame_out;
  logic        o_done;

  int          total_cnt;
  int          bad_cnt;
  logic [63:0] exp_words [$];
  logic [63:0] got_words [$];
  int          exp_t;

  mac_frame_gen #(
    .PAYLOAD_MAX_SIZE     (MAXP),
    .PAYLOAD_CHAR_PATTERN (8'h00),
    .PAYLOAD_LENGTH       (46)
  ) dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_dest_address   (i_dest_address),
    .i_src_address    (i_src_address),
    .i_eth_type       (i_eth_type),
    .i_payload_length (i_payload_length),
    .i_payload        (i_payload),
    .o_valid          (o_valid),
    .o_frame_out      (o_frame_out),
    .o_done           (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d)", total_cnt);
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-serial MSB-first CRC register over bytes sent LSB first; no final inversion
  function automatic logic [31:0] crc_raw(input logic [7:0] bq [$], input int first, input int last_excl);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = first; i < last_excl; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ bq[i][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return c;
  endfunction

  // Reference frame from the bench's own stimulus
  task automatic build_model();
    logic [7:0]  fb [$];
    logic [47:0] t48;
    logic [31:0] c, fcs;
    logic [63:0] w;
    int          l, p;
    l = (i_payload_length == 16'd0) ? 46 : int'(i_payload_length);
    if (l > MAXP) l = MAXP;
    p = (l < 46) ? 46 : l;
    repeat (7) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 0; i < 6; i++) begin t48 = i_dest_address >> (8 * (5 - i)); fb.push_back(t48[7:0]); end
    for (int i = 0; i < 6; i++) begin t48 = i_src_address  >> (8 * (5 - i)); fb.push_back(t48[7:0]); end
    fb.push_back(i_eth_type[15:8]);
    fb.push_back(i_eth_type[7:0]);
    for (int i = 0; i < p; i++) fb.push_back((i < l) ? i_payload[i] : 8'h00);
    c = ~crc_raw(fb, 8, fb.size());
    for (int b = 0; b < 32; b++) fcs[b] = c[31 - b];
    for (int i = 0; i < 4; i++) begin fb.push_back(fcs[7:0]); fcs = fcs >> 8; end
    exp_t = fb.size();
    while (fb.size() % 8 != 0) fb.push_back(8'h00);
    exp_words.delete();
    for (int k = 0; k < fb.size() / 8; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = w | (64'(fb[8*k + j]) << (8 * j));
      exp_words.push_back(w);
    end
  endtask

  function automatic logic [31:0] residue_of_got(input int t);
    logic [7:0]  bq [$];
    logic [63:0] w;
    for (int i = 0; i < got_words.size() * 8; i++) begin
      w = got_words[i / 8] >> (8 * (i % 8));
      bq.push_back(w[7:0]);
    end
    if (bq.size() < t) return 32'h0;
    return crc_raw(bq, 8, t);
  endfunction

  task automatic set_fields(input logic [15:0] len, input int fill);
    i_dest_address   = {$urandom, $urandom};
    i_src_address    = {$urandom, $urandom};
    i_eth_type       = 16'($urandom);
    i_payload_length = len;
    for (int i = 0; i < MAXP; i++) i_payload[i] = (fill < 0) ? 8'($urandom) : 8'(fill);
  endtask

  task automatic run_frame(input string tag, input int hold, input bit glitch);
    int n, cyc, w, k;
    bit ok;
    build_model();
    w = exp_words.size();
    @(negedge clk);
    i_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 20);
    check_eq({tag, ".latency"}, 64'(n), 64'd1);
    check_eq({tag, ".done_cleared"}, 64'(o_done), 64'd0);
    got_words.delete();
    cyc = 1;
    while (o_valid && got_words.size() < 40) begin
      got_words.push_back(o_frame_out);
      k = got_words.size() - 1;
      if (hold > 0) i_start = (cyc < hold);
      else if (glitch && k >= 1 && k <= w - 3) i_start = 1'($urandom_range(0, 1));
      else i_start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, ".nwords"}, 64'(got_words.size()), 64'(w));
    for (int i = 0; i < w && i < got_words.size(); i++)
      check_eq($sformatf("%s.w%0d", tag, i), got_words[i], exp_words[i]);
    check_eq({tag, ".done"}, 64'(o_done), 64'd1);
    check_eq({tag, ".idle_zero"}, o_frame_out, 64'd0);
    if (hold > 0) begin
      ok = 1'b1;
      while (cyc < hold) begin
        if (o_valid || !o_done) ok = 1'b0;
        @(negedge clk);
        cyc++;
      end
      check_eq({tag, ".no_retrigger"}, 64'(ok), 64'd1);
    end
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq({tag, ".done_sticky"}, 64'({o_done, o_valid}), 64'b10);
  endtask

  initial begin
    int n;
    logic [63:0] lw;
    total_cnt = 0;
    bad_cnt   = 0;
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_dest_address   = '0;
    i_src_address    = '0;
    i_eth_type       = '0;
    i_payload_length = '0;
    for (int i = 0; i < MAXP; i++) i_payload[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset.valid", 64'(o_valid), 64'd0);
    check_eq("reset.done", 64'(o_done), 64'd0);
    check_eq("reset.frame", o_frame_out, 64'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // small payload, pad region of the array filled with junk that must not appear
    set_fields(16'd6, -1);
    i_dest_address = 48'hFFFFFFFFFFFF;
    i_src_address  = 48'h112233445566;
    i_eth_type     = 16'h0800;
    i_payload[0] = 8'hDE; i_payload[1] = 8'hAD; i_payload[2] = 8'hBE;
    i_payload[3] = 8'hEF; i_payload[4] = 8'h12; i_payload[5] = 8'h34;
    run_frame("small", 0, 1'b0);
    check_eq("small.nwords9", 64'(got_words.size()), 64'd9);
    check_eq("small.word0", got_words[0], 64'hD555555555555555);
    check_eq("small.word1", got_words[1], 64'h2211FFFFFFFFFFFF);
    check_eq("small.word2", got_words[2], 64'hADDE000866554433);
    check_eq("small.residue", 64'(residue_of_got(exp_t)), 64'hC704DD7B);

    set_fields(16'd46, 8'hAA);
    run_frame("len46", 0, 1'b0);
    check_eq("len46.residue", 64'(residue_of_got(exp_t)), 64'hC704DD7B);

    set_fields(16'd100, -1);
    run_frame("clamp", 0, 1'b0);
    check_eq("clamp.nwords12", 64'(got_words.size()), 64'd12);
    lw = got_words[got_words.size() - 1];
    check_eq("clamp.tail_zero", lw >> 16, 64'd0);
    check_eq("clamp.residue", 64'(residue_of_got(exp_t)), 64'hC704DD7B);

    set_fields(16'd0, -1);
    run_frame("len0", 0, 1'b0);

    set_fields(16'd20, -1);
    run_frame("hold", 50, 1'b0);

    // reset in the middle of a frame
    set_fields(16'd60, -1);
    @(negedge clk);
    i_start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_valid && n < 20);
    check_eq("rst_mid.started", 64'(o_valid), 64'd1);
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    i_rst   = 1'b1;
    #1;
    check_eq("rst_mid.valid", 64'(o_valid), 64'd0);
    check_eq("rst_mid.done", 64'(o_done), 64'd0);
    check_eq("rst_mid.frame", o_frame_out, 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid.no_partial_done", 64'({o_done, o_valid}), 64'd0);
    set_fields(16'($urandom_range(1, 64)), -1);
    run_frame("post_rst", 0, 1'b0);

    for (int t = 0; t < 15; t++) begin
      set_fields(16'($urandom_range(0, 120)), -1);
      run_frame($sformatf("rand%0d", t), 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
